// File: rtl/shift_sequencer_if.sv
// Request/response bundle between the CPU shift-class issue logic and the shift sequencer.
interface shift_sequencer_if;
   logic       start;
   logic [1:0] opcode;
   logic [7:0] amount;
   logic [7:0] data;
   logic [7:0] result;
   logic       busy;
   logic       done;

   modport master (output start, opcode, amount, data, input result, busy, done);
   modport slave  (input start, opcode, amount, data, output result, busy, done);
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA/ROR unit: splits an 8-bit shift amount into passes of at most MAX_STEP bits.
// busy stalls PC update while shifting; done is a one-cycle pulse with result held until the next accepted start.
module shift_sequencer #(
   parameter int WIDTH    = 8,
   parameter int MAX_STEP = 7
) (
   input  logic            clk,
   input  logic            rst,
   shift_sequencer_if.slave bus
);
   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;

   typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

   state_t           state;
   logic [WIDTH-1:0] work;
   logic [1:0]       op;
   logic             sign;
   logic [3:0]       rem;
   logic [WIDTH-1:0] result;
   logic             busy;
   logic             done;

   logic             accept;
   logic [3:0]       eff;
   logic [2:0]       step;
   logic [WIDTH-1:0] shifted;

   function automatic logic [WIDTH-1:0] step_op(input logic [WIDTH-1:0] x, input logic [1:0] o,
                                                input logic [2:0] s, input logic sgn);
      logic [WIDTH-1:0] ones;
      ones = '1;
      case (o)
         OP_SLL:  step_op = x << s;
         OP_SRL:  step_op = x >> s;
         // Fill comes from the latched sign, not the working value's top bit.
         OP_SRA:  step_op = (x >> s) | (sgn ? ~(ones >> s) : '0);
         default: step_op = (x >> s) | (x << (4'd8 - {1'b0, s}));
      endcase
   endfunction

   assign accept = bus.start && (state != SHIFT);

   always_comb begin
      eff = 4'd0;
      if (bus.opcode == 2'b11)
         eff = {1'b0, bus.amount[2:0]};
      else if (bus.amount >= 8'd8)
         eff = 4'd8;
      else
         eff = bus.amount[3:0];
   end

   assign step    = (rem > 4'(MAX_STEP)) ? 3'(MAX_STEP) : rem[2:0];
   assign shifted = step_op(work, op, step, sign);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         work   <= '0;
         op     <= 2'b00;
         sign   <= 1'b0;
         rem    <= 4'd0;
         result <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            SHIFT: begin
               work <= shifted;
               rem  <= rem - {1'b0, step};
               if (rem == {1'b0, step}) begin
                  result <= shifted;
                  state  <= FINISH;
                  busy   <= 1'b0;
                  done   <= 1'b1;
               end
            end
            default: begin
               busy <= 1'b0;
               if (accept) begin
                  work <= bus.data;
                  op   <= bus.opcode;
                  sign <= bus.data[WIDTH-1];
                  if (eff == 4'd0) begin
                     result <= bus.data;
                     state  <= FINISH;
                     done   <= 1'b1;
                  end else begin
                     rem   <= eff;
                     state <= SHIFT;
                     busy  <= 1'b1;
                  end
               end else begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end

   assign bus.result = result;
   assign bus.busy   = busy;
   assign bus.done   = done;
endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: directed operations push expected results, a negedge monitor checks each done pulse.
module tb_shift_sequencer;
   logic clk;
   logic rst;
   int   cyc;
   int   checks;
   int   passes;
   int   bcnt;

   typedef struct {
      logic [7:0] res;
      int         edges;
      int         busy_cycles;
      int         acc;
      string      name;
   } exp_t;

   exp_t q[$];

   shift_sequencer_if bus ();

   shift_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act == req) passes++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, req);
   endtask

   // Monitor: compares every done pulse against the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         bcnt = 0;
      end else if (bus.done) begin
         if (q.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            e = q.pop_front();
            check({e.name, "_result"}, int'(bus.result), int'(e.res));
            check({e.name, "_latency"}, cyc - e.acc, e.edges);
            check({e.name, "_busy_cycles"}, bcnt, e.busy_cycles);
            check({e.name, "_busy_at_done"}, int'(bus.busy), 0);
         end
         bcnt = 0;
      end else if (bus.busy) begin
         bcnt++;
      end
   end

   // Drives one start pulse; returns 1ns after the accept edge.
   task automatic issue(input string name, input logic [1:0] opc, input logic [7:0] amt,
                        input logic [7:0] dat, input logic [7:0] res, input int edges,
                        input int bc, input bit expect_done);
      exp_t e;
      @(posedge clk);
      #1;
      bus.start  = 1'b1;
      bus.opcode = opc;
      bus.amount = amt;
      bus.data   = dat;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (expect_done) begin
         e.res = res; e.edges = edges; e.busy_cycles = bc; e.acc = cyc; e.name = name;
         q.push_back(e);
      end
   endtask

   initial begin
      checks = 0;
      passes = 0;
      bcnt   = 0;
      cyc    = 0;
      bus.start  = 1'b0;
      bus.opcode = 2'b00;
      bus.amount = 8'd0;
      bus.data   = 8'd0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_result", int'(bus.result), 8'h00);
      check("reset_busy", int'(bus.busy), 0);
      check("reset_done", int'(bus.done), 0);

      issue("sll3", 2'b00, 8'd3, 8'hA9, 8'h48, 1, 1, 1'b1); repeat (4) @(posedge clk);
      issue("srl3", 2'b01, 8'd3, 8'hA9, 8'h15, 1, 1, 1'b1); repeat (4) @(posedge clk);
      issue("sra3", 2'b10, 8'd3, 8'hA9, 8'hF5, 1, 1, 1'b1); repeat (4) @(posedge clk);
      issue("ror3", 2'b11, 8'd3, 8'hA9, 8'h35, 1, 1, 1'b1); repeat (4) @(posedge clk);
      issue("sll200", 2'b00, 8'd200, 8'hA9, 8'h00, 2, 2, 1'b1); repeat (4) @(posedge clk);
      issue("sra9", 2'b10, 8'd9, 8'h80, 8'hFF, 2, 2, 1'b1); repeat (4) @(posedge clk);
      issue("ror8", 2'b11, 8'd8, 8'hA9, 8'hA9, 0, 0, 1'b1); repeat (4) @(posedge clk);

      // Start pulse while shifting must be dropped and the operands ignored.
      issue("sra8_ignore", 2'b10, 8'd8, 8'hA9, 8'hFF, 2, 2, 1'b1);
      bus.start  = 1'b1;
      bus.opcode = 2'b00;
      bus.amount = 8'd1;
      bus.data   = 8'h0F;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (5) @(posedge clk);

      // Second request lands in the first one's FINISH cycle.
      issue("b2b_first", 2'b01, 8'd3, 8'hA9, 8'h15, 1, 1, 1'b1);
      issue("b2b_second", 2'b00, 8'd7, 8'h01, 8'h80, 1, 1, 1'b1);
      repeat (5) @(posedge clk);

      // Abort mid-shift: outputs clear at once and no done follows.
      issue("abort", 2'b00, 8'd8, 8'hA9, 8'h00, 2, 2, 1'b0);
      check("abort_busy_before", int'(bus.busy), 1);
      check("abort_result_before", int'(bus.result), 8'h80);
      rst = 1'b1;
      #1;
      check("abort_result", int'(bus.result), 8'h00);
      check("abort_busy", int'(bus.busy), 0);
      check("abort_done", int'(bus.done), 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("idle_after_abort", int'(bus.busy), 0);
      check("pending_expectations", q.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation still running at %0t", $time);
      $fatal(1);
   end
endmodule
